// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage access controller.
package mem_access_ctrl_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } state_t;

  localparam int unsigned TimeoutMaxDefault = 15;
  localparam int unsigned CntWidth          = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] alu_result;
    logic [31:0] instr;
    logic [31:0] pc_plus_4;
    logic        regwrite;
    logic        memtoreg;
    logic        jal;
    logic        regdst;
    logic        misalign;
    logic        bus_err;
  } wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; bubble clears all fields and has priority over load.
module mem_wb_reg
  import mem_access_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic bubble,
  input  wb_t  d,
  output wb_t  q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: request FSM, wait-timeout counter, stall and WB control.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_MAX = TimeoutMaxDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_plus_4_ex,
  input  logic [31:0] alu_result_ex,
  input  logic [31:0] instr_ex,
  input  logic [31:0] wdata_ex,
  input  logic        memwrite_ex,
  input  logic        memtoreg_ex,
  input  logic        regwrite_ex,
  input  logic        jal_ex,
  input  logic        regdst_ex,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] rdata_wb,
  output logic [31:0] alu_result_wb,
  output logic [31:0] instr_wb,
  output logic [31:0] pc_plus_4_wb,
  output logic        regwrite_wb,
  output logic        memtoreg_wb,
  output logic        jal_wb,
  output logic        regdst_wb,
  output logic        misalign_wb,
  output logic        bus_err_wb
);

  localparam logic [CntWidth-1:0] TimeoutCnt = CntWidth'(TIMEOUT_MAX);

  state_t              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                mem_op, aligned, in_wait, timeout;
  logic                wb_load;
  wb_t                 wb_d, wb_q;

  assign mem_op  = memwrite_ex | memtoreg_ex;
  assign aligned = (alu_result_ex[1:0] == 2'b00);
  assign in_wait = (state_q == StWait);
  assign timeout = in_wait & (cnt_q == TimeoutCnt) & ~dmem_ack;

  assign mem_stall  = (~in_wait & mem_op & aligned) | (in_wait & ~dmem_ack & ~timeout);
  assign dmem_req   = in_wait;
  assign dmem_we    = memwrite_ex;
  assign dmem_addr  = alu_result_ex;
  assign dmem_wdata = wdata_ex;

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    wb_load            = 1'b0;
    wb_d               = '0;
    wb_d.alu_result    = alu_result_ex;
    wb_d.instr         = instr_ex;
    wb_d.pc_plus_4     = pc_plus_4_ex;
    wb_d.regwrite      = regwrite_ex;
    wb_d.memtoreg      = memtoreg_ex;
    wb_d.jal           = jal_ex;
    wb_d.regdst        = regdst_ex;
    case (state_q)
      StIdle: begin
        if (mem_op && aligned) begin
          state_d = StWait;
          cnt_d   = '0;
        end else begin
          // Misaligned accesses never reach the bus; they retire flagged and without writeback.
          wb_load = 1'b1;
          if (mem_op) begin
            wb_d.misalign = 1'b1;
            wb_d.regwrite = 1'b0;
            wb_d.memtoreg = 1'b0;
          end
        end
      end
      StWait: begin
        if (dmem_ack) begin
          state_d    = StIdle;
          cnt_d      = '0;
          wb_load    = 1'b1;
          wb_d.rdata = dmem_rdata;
        end else if (timeout) begin
          state_d       = StIdle;
          cnt_d         = '0;
          wb_load       = 1'b1;
          wb_d.bus_err  = 1'b1;
          wb_d.regwrite = 1'b0;
          wb_d.memtoreg = 1'b0;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (wb_load),
    .bubble (mem_stall),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign rdata_wb      = wb_q.rdata;
  assign alu_result_wb = wb_q.alu_result;
  assign instr_wb      = wb_q.instr;
  assign pc_plus_4_wb  = wb_q.pc_plus_4;
  assign regwrite_wb   = wb_q.regwrite;
  assign memtoreg_wb   = wb_q.memtoreg;
  assign jal_wb        = wb_q.jal;
  assign regdst_wb     = wb_q.regdst;
  assign misalign_wb   = wb_q.misalign;
  assign bus_err_wb    = wb_q.bus_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; a monitor pops expected WB records whenever WB is non-empty.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_plus_4_ex = '0, alu_result_ex = '0, instr_ex = '0, wdata_ex = '0;
  logic        memwrite_ex = 1'b0, memtoreg_ex = 1'b0, regwrite_ex = 1'b0;
  logic        jal_ex = 1'b0, regdst_ex = 1'b0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        mem_stall;
  logic [31:0] rdata_wb, alu_result_wb, instr_wb, pc_plus_4_wb;
  logic        regwrite_wb, memtoreg_wb, jal_wb, regdst_wb, misalign_wb, bus_err_wb;

  int  n_pass  = 0;
  int  n_total = 0;
  wb_t exp_q[$];
  wb_t got;

  mem_access_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc_plus_4_ex  (pc_plus_4_ex),
    .alu_result_ex (alu_result_ex),
    .instr_ex      (instr_ex),
    .wdata_ex      (wdata_ex),
    .memwrite_ex   (memwrite_ex),
    .memtoreg_ex   (memtoreg_ex),
    .regwrite_ex   (regwrite_ex),
    .jal_ex        (jal_ex),
    .regdst_ex     (regdst_ex),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .mem_stall     (mem_stall),
    .rdata_wb      (rdata_wb),
    .alu_result_wb (alu_result_wb),
    .instr_wb      (instr_wb),
    .pc_plus_4_wb  (pc_plus_4_wb),
    .regwrite_wb   (regwrite_wb),
    .memtoreg_wb   (memtoreg_wb),
    .jal_wb        (jal_wb),
    .regdst_wb     (regdst_wb),
    .misalign_wb   (misalign_wb),
    .bus_err_wb    (bus_err_wb)
  );

  always #5 clk = ~clk;

  always_comb begin
    got = '{rdata: rdata_wb, alu_result: alu_result_wb, instr: instr_wb,
            pc_plus_4: pc_plus_4_wb, regwrite: regwrite_wb, memtoreg: memtoreg_wb,
            jal: jal_wb, regdst: regdst_wb, misalign: misalign_wb, bus_err: bus_err_wb};
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  // Every non-bubble WB value must match the next queued expectation.
  initial begin
    wb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (got !== '0) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL wb_unexpected: got %0h want bubble", got);
        end else begin
          e = exp_q.pop_front();
          if (got === e) n_pass++;
          else $display("FAIL wb_record: got %0h want %0h", got, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] ins,
                        input logic [31:0] wd, input logic mw, input logic mtr, input logic rw,
                        input logic jl, input logic rd);
    pc_plus_4_ex  = pc;
    alu_result_ex = alu;
    instr_ex      = ins;
    wdata_ex      = wd;
    memwrite_ex   = mw;
    memtoreg_ex   = mtr;
    regwrite_ex   = rw;
    jal_ex        = jl;
    regdst_ex     = rd;
  endtask

  // Expected WB record built from the bench's own copy of the EX inputs.
  function automatic wb_t ex_wb(input logic [31:0] rd_data, input logic rw, input logic mtr,
                                input logic mis, input logic be);
    wb_t w;
    w = '{rdata: rd_data, alu_result: alu_result_ex, instr: instr_ex, pc_plus_4: pc_plus_4_ex,
          regwrite: rw, memtoreg: mtr, jal: jal_ex, regdst: regdst_ex, misalign: mis,
          bus_err: be};
    return w;
  endfunction

  initial begin
    // Reset state
    #2;
    chk("reset_wb", got, 0);
    chk("reset_req", dmem_req, 0);
    chk("reset_stall", mem_stall, 0);
    tick();
    rst = 1'b1;

    // ALU pass-through, two patterns
    set_ex(32'h1004, 32'h1234, 32'h00A0_0013, 32'h0, 0, 0, 1, 0, 1);
    #1;
    chk("alu_stall", mem_stall, 0);
    chk("alu_req", dmem_req, 0);
    exp_q.push_back(ex_wb(32'h0, 1, 0, 0, 0));
    tick();
    set_ex(32'h1008, 32'h0000_1008, 32'h0C00_0400, 32'h0, 0, 0, 1, 1, 0);
    #1;
    chk("jal_stall", mem_stall, 0);
    exp_q.push_back(ex_wb(32'h0, 1, 0, 0, 0));
    tick();

    // Load at 0x100, ack in first WAIT cycle
    set_ex(32'h2004, 32'h100, 32'h8C01_0100, 32'h0, 0, 1, 1, 0, 0);
    #1;
    chk("ld_idle_stall", mem_stall, 1);
    chk("ld_idle_req", dmem_req, 0);
    tick();
    chk("ld_bubble", instr_wb, 0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld_wait_req", dmem_req, 1);
    chk("ld_wait_stall", mem_stall, 0);
    chk("ld_addr", dmem_addr, 32'h100);
    exp_q.push_back(ex_wb(32'hDEAD_BEEF, 1, 1, 0, 0));
    tick();
    dmem_ack = 1'b0;

    // Store at 0x204, three WAIT cycles without ack then ack
    set_ex(32'h3004, 32'h204, 32'hAC02_0204, 32'hA5A5_A5A5, 1, 0, 0, 0, 0);
    dmem_rdata = 32'h1111_1111;
    #1;
    chk("st_idle_stall", mem_stall, 1);
    chk("st_idle_req", dmem_req, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) dmem_ack = 1'b1;
      #1;
      chk($sformatf("st_req_%0d", k), dmem_req, 1);
      chk($sformatf("st_stall_%0d", k), mem_stall, (k == 3) ? 0 : 1);
      chk($sformatf("st_bus_%0d", k), {dmem_we, dmem_addr, dmem_wdata},
          {1'b1, 32'h204, 32'hA5A5_A5A5});
      if (k < 3) chk($sformatf("st_bubble_%0d", k), instr_wb, 0);
    end
    exp_q.push_back(ex_wb(32'h1111_1111, 0, 0, 0, 0));
    tick();
    dmem_ack = 1'b0;

    // Misaligned load at 0x102
    set_ex(32'h4004, 32'h102, 32'h8C03_0102, 32'h0, 0, 1, 1, 0, 0);
    #1;
    chk("mis_req", dmem_req, 0);
    chk("mis_stall", mem_stall, 0);
    exp_q.push_back(ex_wb(32'h0, 0, 0, 1, 0));
    tick();
    #1;
    chk("mis_req_after", dmem_req, 0);

    // Load with no ack: timeout on the 16th WAIT cycle
    set_ex(32'h5004, 32'h300, 32'h8C04_0300, 32'h0, 0, 1, 1, 0, 1);
    dmem_rdata = 32'h0;
    tick();
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("to_req_%0d", k), dmem_req, 1);
      chk($sformatf("to_stall_%0d", k), mem_stall, (k == 15) ? 0 : 1);
      if (k == 15) exp_q.push_back(ex_wb(32'h0, 0, 0, 0, 1));
      tick();
    end
    #1;
    chk("to_req_after", dmem_req, 0);

    // Ack arriving when the counter reaches 15 wins over timeout
    set_ex(32'h6004, 32'h304, 32'h8C05_0304, 32'h0, 0, 1, 1, 0, 1);
    tick();
    for (int k = 0; k < 16; k++) begin
      if (k == 15) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
      end
      #1;
      chk($sformatf("ack15_stall_%0d", k), mem_stall, (k == 15) ? 0 : 1);
      if (k == 15) exp_q.push_back(ex_wb(32'hCAFE_F00D, 1, 1, 0, 0));
      tick();
    end
    dmem_ack = 1'b0;

    // Asynchronous reset clears a populated WB register
    set_ex(32'h7004, 32'h7777, 32'h0000_7777, 32'h0, 0, 0, 1, 0, 0);
    exp_q.push_back(ex_wb(32'h0, 1, 0, 0, 0));
    tick();
    rst = 1'b0;
    #1;
    chk("rst_wb_clear", got, 0);
    rst = 1'b1;

    // Reset during WAIT drops the request and a later ack is ignored
    set_ex(32'h8004, 32'h400, 32'h8C06_0400, 32'h0, 0, 1, 1, 0, 0);
    tick();
    #1;
    chk("rw_req_before", dmem_req, 1);
    rst = 1'b0;
    #1;
    chk("rw_req_dropped", dmem_req, 0);
    chk("rw_stall_idle", mem_stall, 1);
    chk("rw_wb_clear", got, 0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h9999_9999;
    tick();
    tick();
    rst = 1'b1;
    set_ex(32'h9004, 32'h9abc, 32'h0000_9abc, 32'h0, 0, 0, 1, 0, 1);
    #1;
    chk("late_ack_req", dmem_req, 0);
    chk("late_ack_stall", mem_stall, 0);
    exp_q.push_back(ex_wb(32'h0, 1, 0, 0, 0));
    tick();
    dmem_ack = 1'b0;
    set_ex(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 rising-edge clock; rst in 1 asynchronous active-low reset.
REQ-002 SHALL have EX/MEM-side inputs:
  - pc_plus_4_ex in 32.
  - alu_result_ex in 32: data address or ALU result.
  - instr_ex in 32.
  - wdata_ex in 32: store data.
  - memwrite_ex, memtoreg_ex, regwrite_ex, jal_ex, regdst_ex in 1 each.
REQ-003 SHALL have memory-side ports:
  - dmem_req out 1; dmem_we out 1.
  - dmem_addr out 32; dmem_wdata out 32.
  - dmem_ack in 1; dmem_rdata in 32.
REQ-004 SHALL have pipeline outputs:
  - mem_stall out 1: hold EX/MEM and upstream.
  - rdata_wb, alu_result_wb, instr_wb, pc_plus_4_wb out 32 each.
  - regwrite_wb, memtoreg_wb, jal_wb, regdst_wb out 1 each.
  - misalign_wb, bus_err_wb out 1 each.
REQ-005 SHALL define parameter TIMEOUT_MAX, default 15: maximum WAIT cycles without dmem_ack.

Function
REQ-006 SHALL define mem_op = memwrite_ex | memtoreg_ex and aligned = (alu_result_ex[1:0] == 0).
REQ-007 SHALL implement FSM states IDLE and WAIT.
  - IDLE with mem_op & aligned -> WAIT at next edge.
  - Otherwise remain in IDLE.
REQ-008 In WAIT, dmem_req SHALL be 1; it SHALL be 0 in IDLE.
  - dmem_we = memwrite_ex; dmem_addr = alu_result_ex; dmem_wdata = wdata_ex, all combinational.
  - Inputs are guaranteed stable because of mem_stall.
REQ-009 mem_stall SHALL be (IDLE & mem_op & aligned) | (WAIT & ~dmem_ack & ~timeout), combinational.
REQ-010 In WAIT with dmem_ack=1:
  - Next edge SHALL load the WB register from EX inputs, with rdata_wb = dmem_rdata.
  - FSM returns to IDLE.
  - Minimum memory-op latency is 2 cycles.
REQ-011 SHALL run a 4-bit wait counter: cleared on entering WAIT, incremented each WAIT cycle without ack.
  - timeout = (counter == TIMEOUT_MAX) & ~dmem_ack.
REQ-012 On timeout:
  - Next edge SHALL load the WB register with bus_err_wb=1, regwrite_wb=0, memtoreg_wb=0, other fields from EX inputs.
  - FSM returns to IDLE.
REQ-013 If dmem_ack and counter == TIMEOUT_MAX occur in the same cycle, ack SHALL win: normal completion, bus_err_wb=0.
REQ-014 In IDLE with mem_op & ~aligned:
  - No request SHALL be issued and no stall raised.
  - WB register loads with misalign_wb=1, regwrite_wb=0, memtoreg_wb=0.
REQ-015 In IDLE with ~mem_op, the WB register SHALL load from EX inputs every edge, rdata_wb=0, flags 0: zero-latency pass-through.
REQ-016 On every edge where mem_stall=1, the WB register SHALL load a bubble: all fields 0. No instruction reaches WB twice.
REQ-017 dmem_ack while in IDLE SHALL be ignored.
REQ-018 misalign_wb and bus_err_wb SHALL be one-cycle flags tied to the WB instruction; they are never set together.

Reset
REQ-019 rst=0 SHALL asynchronously force:
  - State IDLE, counter 0.
  - All WB outputs 0, dmem_req 0.
  - mem_stall follows REQ-009 in IDLE.
REQ-020 Reset asserted in WAIT SHALL drop dmem_req immediately. The outstanding access is abandoned and a late dmem_ack is ignored.

Structure
REQ-021 Shared package SHALL hold:
  - State encoding: IDLE=0, WAIT=1.
  - TIMEOUT_MAX default.
  - Counter width (4).
REQ-022 The WB register SHALL be one sub-module, mem_wb_reg, with load/bubble control and asynchronous active-low reset. FSM, counter and stall logic SHALL be in mem_access_ctrl.

Verification
REQ-023 Benches SHALL cover these scenarios:
  - ALU op, alu_result_ex=0x1234, regwrite_ex=1 -> next edge alu_result_wb=0x1234, regwrite_wb=1, mem_stall never 1.
  - Load at 0x100, ack in 1st WAIT cycle, rdata=0xDEADBEEF -> stall 1 cycle; edge 2 gives rdata_wb=0xDEADBEEF, memtoreg_wb=1; bubble in WB on edge 1.
  - Store at 0x204, wdata=0xA5A5A5A5, ack after 3 WAIT cycles -> dmem_we=1 and addr/data stable for 4 cycles; exactly one dmem_req burst; bubbles in WB during stall.
  - Load at 0x102 -> no dmem_req; next edge misalign_wb=1, regwrite_wb=0; no stall.
  - Load, no ack -> timeout after 16 WAIT cycles; bus_err_wb=1, regwrite_wb=0. Repeat with ack at counter=15 -> normal completion, bus_err_wb=0.
  - rst low during WAIT -> dmem_req 0 immediately; all WB outputs 0; a later ack is ignored.
